// File: rtl/bip_datapath_ext_if.sv
// Handshake and bus bundle between the BIP control unit / data memory
// and the accumulator datapath.
interface bip_datapath_ext_if #(
    parameter int DATA_W    = 16,
    parameter int OPERAND_W = 11,
    parameter int ADDR_W    = 11
) ();
    logic                 i_valid;
    logic                 o_ready;
    logic [1:0]           i_sel_a;
    logic                 i_sel_b;
    logic                 i_write_acc;
    logic [2:0]           i_op;
    logic [OPERAND_W-1:0] i_operando;
    logic [DATA_W-1:0]    i_memory_data;
    logic [DATA_W-1:0]    o_memory_data;
    logic [ADDR_W-1:0]    o_data_addr;
    logic [3:0]           o_flags;
    logic                 o_done;

    // Control unit / memory side.
    modport master (
        output i_valid, i_sel_a, i_sel_b, i_write_acc, i_op, i_operando, i_memory_data,
        input  o_ready, o_memory_data, o_data_addr, o_flags, o_done
    );

    // Datapath side.
    modport slave (
        input  i_valid, i_sel_a, i_sel_b, i_write_acc, i_op, i_operando, i_memory_data,
        output o_ready, o_memory_data, o_data_addr, o_flags, o_done
    );
endinterface

// File: rtl/bip_datapath_ext.sv
// BIP accumulator datapath: ALU (add/sub/logic), serial one-bit-per-clock
// shifts, registered {N,Z,C,V} flags and a valid/ready handshake.
module bip_datapath_ext #(
    parameter int DATA_W    = 16,
    parameter int OPERAND_W = 11,
    parameter int ADDR_W    = 11
) (
    input  logic             i_clk,
    input  logic             i_reset,
    bip_datapath_ext_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
        OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SRA = 3'b110, OP_RSV = 3'b111
    } op_t;

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              shift_left;
    logic              flag_n, flag_z, flag_c, flag_v;
    logic              done;

    op_t               op;
    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] b_opnd;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_v;
    logic              is_shift;
    logic [CNT_W-1:0]  amt;
    logic [DATA_W-1:0] shift_val;
    logic              shift_out;

    assign op       = op_t'(bus.i_op);
    assign ext      = DATA_W'($signed(bus.i_operando));
    assign b_opnd   = bus.i_sel_b ? ext : bus.i_memory_data;
    assign load_val = bus.i_sel_a[0] ? ext : bus.i_memory_data;
    assign is_shift = (bus.i_sel_a == 2'b10) && ((op == OP_SHL) || (op == OP_SRA));

    assign bus.o_ready       = (state == IDLE);
    assign bus.o_memory_data = acc;
    assign bus.o_data_addr   = bus.i_operando[ADDR_W-1:0];
    assign bus.o_flags       = {flag_n, flag_z, flag_c, flag_v};
    assign bus.o_done        = done;

    // ALU result with carry/borrow and signed overflow from a DATA_W+1 adder.
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, b_opnd};
        diff    = {1'b0, acc} - {1'b0, b_opnd};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (acc[DATA_W-1] == b_opnd[DATA_W-1]) && (sum[DATA_W-1] != acc[DATA_W-1]);
        case (op)
            OP_SUB: begin
                alu_res = diff[DATA_W-1:0];
                alu_c   = diff[DATA_W];
                alu_v   = (acc[DATA_W-1] != b_opnd[DATA_W-1]) && (diff[DATA_W-1] != acc[DATA_W-1]);
            end
            OP_AND: begin
                alu_res = acc & b_opnd;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            OP_OR: begin
                alu_res = acc | b_opnd;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            OP_XOR: begin
                alu_res = acc ^ b_opnd;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            default: ;
        endcase
    end

    // Shift amount saturated to DATA_W, and the next single-bit shift step.
    always_comb begin
        amt = b_opnd[CNT_W-1:0];
        if (b_opnd > DATA_W'(DATA_W)) begin
            amt = CNT_W'(DATA_W);
        end
        if (shift_left) begin
            shift_val = {acc[DATA_W-2:0], 1'b0};
            shift_out = acc[DATA_W-1];
        end else begin
            shift_val = {acc[DATA_W-1], acc[DATA_W-1:1]};
            shift_out = acc[0];
        end
    end

    // Handshake FSM, accumulator, flags and completion pulse.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            shift_left <= 1'b0;
            flag_n     <= 1'b0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_v     <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        done <= 1'b1;
                        if (bus.i_write_acc) begin
                            case (bus.i_sel_a)
                                2'b00, 2'b01: begin
                                    acc    <= load_val;
                                    flag_n <= load_val[DATA_W-1];
                                    flag_z <= (load_val == '0);
                                end
                                2'b10: begin
                                    if (is_shift) begin
                                        if (amt == '0) begin
                                            flag_n <= acc[DATA_W-1];
                                            flag_z <= (acc == '0);
                                            flag_c <= 1'b0;
                                            flag_v <= 1'b0;
                                        end else begin
                                            // Completion is signalled from SHIFT instead.
                                            done       <= 1'b0;
                                            cnt        <= amt;
                                            shift_left <= (op == OP_SHL);
                                            state      <= SHIFT;
                                        end
                                    end else begin
                                        acc    <= alu_res;
                                        flag_n <= alu_res[DATA_W-1];
                                        flag_z <= (alu_res == '0);
                                        flag_c <= alu_c;
                                        flag_v <= alu_v;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                SHIFT: begin
                    acc    <= shift_val;
                    flag_c <= shift_out;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= IDLE;
                        flag_n <= shift_val[DATA_W-1];
                        flag_z <= (shift_val == '0);
                        flag_v <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bip_datapath_ext.sv
// Directed-vector bench for bip_datapath_ext with hand-computed expectations.
module tb_bip_datapath_ext;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    bip_datapath_ext_if #(.DATA_W(16), .OPERAND_W(11), .ADDR_W(11)) bus ();

    bip_datapath_ext #(.DATA_W(16), .OPERAND_W(11), .ADDR_W(11)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Present one instruction at a falling edge, hold it through the next rising edge.
    task automatic drive(input logic [1:0] sa, input logic sb, input logic wr,
                         input logic [2:0] op, input logic [10:0] opd, input logic [15:0] mem);
        @(negedge clk);
        bus.i_sel_a       = sa;
        bus.i_sel_b       = sb;
        bus.i_write_acc   = wr;
        bus.i_op          = op;
        bus.i_operando    = opd;
        bus.i_memory_data = mem;
        bus.i_valid       = 1'b1;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        drive(2'b00, 1'b0, 1'b1, 3'b000, 11'h000, 16'h0123);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.o_memory_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_acc_async: got %h expected 0000", bus.o_memory_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.o_memory_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_acc: got %h expected 0000", bus.o_memory_data);
        end
        vectors++;
        if (bus.o_flags !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 0000", bus.o_flags);
        end
        vectors++;
        if (bus.o_ready !== 1'b1 || bus.o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_done: got ready=%b done=%b expected ready=1 done=0",
                     bus.o_ready, bus.o_done);
        end
    endtask

    task automatic test_load();
        drive(2'b01, 1'b0, 1'b1, 3'b000, 11'h7FF, 16'h0000);
        @(negedge clk);
        vectors++;
        if (bus.o_memory_data !== 16'hFFFF || bus.o_flags !== 4'b1000 || bus.o_done !== 1'b1) begin
            miscompares++;
            $display("FAIL load_operand: got acc=%h flags=%b done=%b expected acc=ffff flags=1000 done=1",
                     bus.o_memory_data, bus.o_flags, bus.o_done);
        end
        @(negedge clk);
        vectors++;
        if (bus.o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL load_done_width: got done=%b expected 0", bus.o_done);
        end
    endtask

    task automatic test_arith();
        logic [1:0]  sa [9];
        logic        sb [9];
        logic [2:0]  op [9];
        logic [10:0] opd [9];
        logic [15:0] mem [9];
        logic [15:0] exp_acc [9];
        logic [3:0]  exp_flg [9];
        sa = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        sb = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        op = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b100, 3'b011, 3'b111};
        opd = '{11'h000, 11'h000, 11'h000, 11'h000, 11'h001, 11'h000, 11'h000, 11'h400, 11'h004};
        mem = '{16'h7FFF, 16'h0001, 16'h8000, 16'h8000, 16'h0000, 16'h0F0F, 16'h0F0F, 16'h0000, 16'h0000};
        exp_acc = '{16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'hFFFF, 16'h0F0F, 16'h0000, 16'hFC00, 16'hFC04};
        exp_flg = '{4'b0000, 4'b1001, 4'b1001, 4'b0100, 4'b1010, 4'b0000, 4'b0100, 4'b1000, 4'b1000};
        for (int i = 0; i < 9; i++) begin
            drive(sa[i], sb[i], 1'b1, op[i], opd[i], mem[i]);
            @(negedge clk);
            vectors++;
            if (bus.o_memory_data !== exp_acc[i] || bus.o_flags !== exp_flg[i] || bus.o_done !== 1'b1) begin
                miscompares++;
                $display("FAIL arith_%0d: got acc=%h flags=%b done=%b expected acc=%h flags=%b done=1",
                         i, bus.o_memory_data, bus.o_flags, bus.o_done, exp_acc[i], exp_flg[i]);
            end
        end
    endtask

    task automatic test_shift();
        int low;
        drive(2'b00, 1'b0, 1'b1, 3'b000, 11'h000, 16'h1234);
        drive(2'b10, 1'b1, 1'b1, 3'b101, 11'h003, 16'h0000);
        low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) break;
            low++;
        end
        vectors++;
        if (low !== 3 || bus.o_done !== 1'b1) begin
            miscompares++;
            $display("FAIL shl3_timing: got busy=%0d done=%b expected busy=3 done=1", low, bus.o_done);
        end
        vectors++;
        if (bus.o_memory_data !== 16'h91A0 || bus.o_flags !== 4'b1000) begin
            miscompares++;
            $display("FAIL shl3_result: got acc=%h flags=%b expected acc=91a0 flags=1000",
                     bus.o_memory_data, bus.o_flags);
        end
        drive(2'b00, 1'b0, 1'b1, 3'b000, 11'h000, 16'h8001);
        drive(2'b10, 1'b1, 1'b1, 3'b110, 11'h001, 16'h0000);
        low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) break;
            low++;
        end
        vectors++;
        if (low !== 1 || bus.o_memory_data !== 16'hC000 || bus.o_flags !== 4'b1010 || bus.o_done !== 1'b1) begin
            miscompares++;
            $display("FAIL sra1: got busy=%0d acc=%h flags=%b done=%b expected busy=1 acc=c000 flags=1010 done=1",
                     low, bus.o_memory_data, bus.o_flags, bus.o_done);
        end
        drive(2'b10, 1'b1, 1'b1, 3'b101, 11'h000, 16'h0000);
        @(negedge clk);
        vectors++;
        if (bus.o_ready !== 1'b1 || bus.o_memory_data !== 16'hC000 || bus.o_flags !== 4'b1000 || bus.o_done !== 1'b1) begin
            miscompares++;
            $display("FAIL shl0: got ready=%b acc=%h flags=%b done=%b expected ready=1 acc=c000 flags=1000 done=1",
                     bus.o_ready, bus.o_memory_data, bus.o_flags, bus.o_done);
        end
    endtask

    task automatic test_back_to_back();
        int low;
        drive(2'b00, 1'b0, 1'b1, 3'b000, 11'h000, 16'h0001);
        @(negedge clk);
        bus.i_sel_a = 2'b10; bus.i_sel_b = 1'b0; bus.i_write_acc = 1'b1;
        bus.i_op = 3'b101; bus.i_operando = 11'h000; bus.i_memory_data = 16'd20;
        bus.i_valid = 1'b1;
        @(posedge clk);
        #1;
        // Next instruction is held valid for the whole shift.
        bus.i_sel_a = 2'b00; bus.i_memory_data = 16'h00A5;
        low = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) break;
            low++;
        end
        vectors++;
        if (low !== 16 || bus.o_done !== 1'b1) begin
            miscompares++;
            $display("FAIL shl20_timing: got busy=%0d done=%b expected busy=16 done=1", low, bus.o_done);
        end
        vectors++;
        if (bus.o_memory_data !== 16'h0000 || bus.o_flags !== 4'b0110) begin
            miscompares++;
            $display("FAIL shl20_result: got acc=%h flags=%b expected acc=0000 flags=0110",
                     bus.o_memory_data, bus.o_flags);
        end
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.o_memory_data !== 16'h00A5 || bus.o_done !== 1'b1) begin
            miscompares++;
            $display("FAIL held_valid_accept: got acc=%h done=%b expected acc=00a5 done=1",
                     bus.o_memory_data, bus.o_done);
        end
    endtask

    task automatic test_reset_mid_shift();
        int pulses;
        drive(2'b00, 1'b0, 1'b1, 3'b000, 11'h000, 16'h8000);
        drive(2'b10, 1'b1, 1'b1, 3'b110, 11'h00A, 16'h0000);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.o_memory_data !== 16'h0000 || bus.o_ready !== 1'b1 || bus.o_done !== 1'b0 || bus.o_flags !== 4'b0000) begin
            miscompares++;
            $display("FAIL abort_shift: got acc=%h ready=%b done=%b flags=%b expected acc=0000 ready=1 done=0 flags=0000",
                     bus.o_memory_data, bus.o_ready, bus.o_done, bus.o_flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) pulses++;
        end
        vectors++;
        if (pulses !== 0 || bus.o_memory_data !== 16'h0000 || bus.o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_quiet: got done_pulses=%0d acc=%h ready=%b expected 0 0000 1",
                     pulses, bus.o_memory_data, bus.o_ready);
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        bus.i_sel_a = 2'b00; bus.i_sel_b = 1'b0; bus.i_write_acc = 1'b0;
        bus.i_op = 3'b000; bus.i_operando = 11'h2AB; bus.i_memory_data = 16'h1111;
        bus.i_valid = 1'b1;
        #1;
        vectors++;
        if (bus.o_data_addr !== 11'h2AB) begin
            miscompares++;
            $display("FAIL store_addr: got %h expected 2ab", bus.o_data_addr);
        end
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.o_memory_data !== 16'h0000 || bus.o_done !== 1'b1 || bus.o_flags !== 4'b0000) begin
            miscompares++;
            $display("FAIL store_data: got acc=%h done=%b flags=%b expected acc=0000 done=1 flags=0000",
                     bus.o_memory_data, bus.o_done, bus.o_flags);
        end
        drive(2'b11, 1'b0, 1'b1, 3'b000, 11'h7FF, 16'hBEEF);
        @(negedge clk);
        vectors++;
        if (bus.o_memory_data !== 16'h0000 || bus.o_done !== 1'b1 || bus.o_flags !== 4'b0000) begin
            miscompares++;
            $display("FAIL sel_a_reserved: got acc=%h done=%b flags=%b expected acc=0000 done=1 flags=0000",
                     bus.o_memory_data, bus.o_done, bus.o_flags);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_sel_a = 2'b00; bus.i_sel_b = 1'b0; bus.i_write_acc = 1'b0;
        bus.i_op = 3'b000; bus.i_operando = '0; bus.i_memory_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_load();
        test_arith();
        test_shift();
        test_back_to_back();
        test_reset_mid_shift();
        test_store();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
